// File: rtl/vga_timing.sv
// vga_timing: pixel-rate raster counters with sync/de decode, delayed to line up
// with the draw-stage pixel pipeline.
module vga_timing #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_POL   = 0,
  parameter int CLK_DIV    = 4,
  parameter int PIPE_DELAY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [10:0] o_x,
  output logic [10:0] o_y,
  output logic        o_pix_en,
  output logic        o_active,
  output logic        o_line_start,
  output logic        o_frame_start,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_de
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic SP = SYNC_POL != 0;
  localparam logic [2:0] IDLE = {1'b0, ~SP, ~SP};

  if (H_TOTAL > 2048 || V_TOTAL > 2048 || CLK_DIV < 1 || PIPE_DELAY < 0) begin : g_bad_cfg
    $error("vga_timing: illegal timing parameters");
  end

  logic [DW-1:0] r_div;
  logic [10:0]   r_x, r_y;
  logic          w_pix_en, w_x_last, w_first, w_hs, w_vs;
  logic [2:0]    w_now, w_out;

  assign w_pix_en = r_div == DW'(CLK_DIV - 1);
  assign w_x_last = r_x == 11'(H_TOTAL - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
      r_x   <= '0;
      r_y   <= '0;
    end else begin
      r_div <= w_pix_en ? '0 : r_div + 1'b1;
      if (w_pix_en) begin
        r_x <= w_x_last ? '0 : r_x + 11'd1;
        if (w_x_last) r_y <= r_y == 11'(V_TOTAL - 1) ? '0 : r_y + 11'd1;
      end
    end
  end

  // Start pulses mark the first clk of a pixel period and stay quiet while in reset.
  assign w_first       = rst_n && r_div == '0;
  assign o_x           = r_x;
  assign o_y           = r_y;
  assign o_pix_en      = w_pix_en;
  assign o_line_start  = w_first && r_x == '0;
  assign o_frame_start = o_line_start && r_y == '0;
  assign o_active      = r_x < 11'(H_ACTIVE) && r_y < 11'(V_ACTIVE);
  assign w_hs = r_x >= 11'(H_ACTIVE + H_FP) && r_x < 11'(H_ACTIVE + H_FP + H_SYNC);
  assign w_vs = r_y >= 11'(V_ACTIVE + V_FP) && r_y < 11'(V_ACTIVE + V_FP + V_SYNC);
  assign w_now = {o_active, w_hs ? SP : ~SP, w_vs ? SP : ~SP};

  if (PIPE_DELAY == 0) begin : g_nopipe
    assign w_out = rst_n ? w_now : IDLE;
  end else begin : g_pipe
    logic [2:0] r_pipe [PIPE_DELAY];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < PIPE_DELAY; i++) r_pipe[i] <= IDLE;
      end else begin
        r_pipe[0] <= w_now;
        for (int i = 1; i < PIPE_DELAY; i++) r_pipe[i] <= r_pipe[i-1];
      end
    end
    assign w_out = r_pipe[PIPE_DELAY-1];
  end

  assign {o_de, o_hsync, o_vsync} = w_out;
endmodule
